// File: rtl/id_stage_if.sv
// ---------------------------------------------------------------------------
// id_stage_if
// Groups the decode stage's bus signals so the fetch/writeback/forwarding
// side and the decode stage share one bundle.
//   Fetch-stage inputs : code_ID, PC_ID, Exc_ID, BD_ID
//   Register write port: WB_we, WB_addr, WB_data
//   Forwarded operands : fwdRsEn, fwdRs, fwdRtEn, fwdRt
//   Next-PC outputs    : cmp, imm16, jmpAddr, jmpReg (combinational)
//   EX-stage outputs   : code_EX, PC_EX, rsData_EX, rtData_EX, Exc_EX, BD_EX
// Modports: master drives the stage inputs, slave is the decode stage itself.
// ---------------------------------------------------------------------------
interface id_stage_if;
  logic [31:0] code_ID;
  logic [31:0] PC_ID;
  logic [6:2]  Exc_ID;
  logic        BD_ID;

  logic        WB_we;
  logic [4:0]  WB_addr;
  logic [31:0] WB_data;

  logic        fwdRsEn;
  logic [31:0] fwdRs;
  logic        fwdRtEn;
  logic [31:0] fwdRt;

  logic        cmp;
  logic [15:0] imm16;
  logic [25:0] jmpAddr;
  logic [31:0] jmpReg;

  logic [31:0] code_EX;
  logic [31:0] PC_EX;
  logic [31:0] rsData_EX;
  logic [31:0] rtData_EX;
  logic [6:2]  Exc_EX;
  logic        BD_EX;

  modport master (
    output code_ID, PC_ID, Exc_ID, BD_ID,
    output WB_we, WB_addr, WB_data,
    output fwdRsEn, fwdRs, fwdRtEn, fwdRt,
    input  cmp, imm16, jmpAddr, jmpReg,
    input  code_EX, PC_EX, rsData_EX, rtData_EX, Exc_EX, BD_EX
  );

  modport slave (
    input  code_ID, PC_ID, Exc_ID, BD_ID,
    input  WB_we, WB_addr, WB_data,
    input  fwdRsEn, fwdRs, fwdRtEn, fwdRt,
    output cmp, imm16, jmpAddr, jmpReg,
    output code_EX, PC_EX, rsData_EX, rtData_EX, Exc_EX, BD_EX
  );
endinterface

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
// Instruction-decode stage of a MIPS-style pipeline: 32x32 register file,
// operand selection with forwarding, branch comparison for the next-PC
// logic, and the ID/EX pipeline registers.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset (clears register file and EX regs)
//   stall - hold the EX registers (register-file writes still happen)
//   clr   - flush the EX registers to zero (wins over stall)
//   bus   - id_stage_if.slave, see rtl/id_stage_if.sv for the signal list
// Build option:
//   GRF_BYPASS_EN - when defined, a same-cycle writeback to the register
//                   being read is passed straight through to the read port.
// ---------------------------------------------------------------------------
module id_stage (
  input logic       clk,
  input logic       reset,
  input logic       stall,
  input logic       clr,
  id_stage_if.slave bus
);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  logic [31:0] r_grf [32];

  logic [31:0] r_codeEx;
  logic [31:0] r_pcEx;
  logic [31:0] r_rsEx;
  logic [31:0] r_rtEx;
  logic [6:2]  r_excEx;
  logic        r_bdEx;

  logic [5:0]  w_opcode;
  logic [4:0]  w_rsAddr;
  logic [4:0]  w_rtAddr;
  logic [31:0] w_rsGrf;
  logic [31:0] w_rtGrf;
  logic [31:0] w_rsVal;
  logic [31:0] w_rtVal;
  logic        w_cmp;

  assign w_opcode = bus.code_ID[31:26];
  assign w_rsAddr = bus.code_ID[25:21];
  assign w_rtAddr = bus.code_ID[20:16];

  // Register-file read ports. Register 0 is hard-wired to zero regardless
  // of array contents; the optional write-through path lets a writeback in
  // the same cycle be seen without waiting for the array update.
  always_comb begin
    w_rsGrf = (w_rsAddr == 5'd0) ? 32'd0 : r_grf[w_rsAddr];
    w_rtGrf = (w_rtAddr == 5'd0) ? 32'd0 : r_grf[w_rtAddr];
`ifdef GRF_BYPASS_EN
    if (bus.WB_we && (bus.WB_addr != 5'd0)) begin
      if (bus.WB_addr == w_rsAddr) begin
        w_rsGrf = bus.WB_data;
      end
      if (bus.WB_addr == w_rtAddr) begin
        w_rtGrf = bus.WB_data;
      end
    end
`endif
  end

  // Forwarded values from later stages are newer than anything in the
  // register file, so they take precedence.
  assign w_rsVal = bus.fwdRsEn ? bus.fwdRs : w_rsGrf;
  assign w_rtVal = bus.fwdRtEn ? bus.fwdRt : w_rtGrf;

  // Branch condition evaluated in decode so the fetch stage can redirect
  // without waiting for EX. The signed tests only need the sign bit and a
  // zero check.
  always_comb begin
    w_cmp = 1'b0;
    case (w_opcode)
      OP_BEQ:  w_cmp = (w_rsVal == w_rtVal);
      OP_BNE:  w_cmp = (w_rsVal != w_rtVal);
      OP_BLEZ: w_cmp = w_rsVal[31] || (w_rsVal == 32'd0);
      OP_BGTZ: w_cmp = !w_rsVal[31] && (w_rsVal != 32'd0);
      OP_REGIMM: begin
        if (w_rtAddr == 5'd0) begin
          w_cmp = w_rsVal[31];
        end else if (w_rtAddr == 5'd1) begin
          w_cmp = !w_rsVal[31];
        end
      end
      default: w_cmp = 1'b0;
    endcase
  end

  assign bus.cmp     = w_cmp;
  assign bus.imm16   = bus.code_ID[15:0];
  assign bus.jmpAddr = bus.code_ID[25:0];
  assign bus.jmpReg  = w_rsVal;

  // Register-file write port. Independent of stall/clr so writebacks are
  // never lost; a write coincident with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_grf[i] <= 32'd0;
      end
    end else if (bus.WB_we && (bus.WB_addr != 5'd0)) begin
      r_grf[bus.WB_addr] <= bus.WB_data;
    end
  end

  // ID/EX pipeline registers. Flush beats stall so a squashed instruction
  // cannot linger in EX while the front end is held.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_codeEx <= 32'd0;
      r_pcEx   <= 32'd0;
      r_rsEx   <= 32'd0;
      r_rtEx   <= 32'd0;
      r_excEx  <= 5'd0;
      r_bdEx   <= 1'b0;
    end else if (!stall) begin
      r_codeEx <= bus.code_ID;
      r_pcEx   <= bus.PC_ID;
      r_rsEx   <= w_rsVal;
      r_rtEx   <= w_rtVal;
      r_excEx  <= bus.Exc_ID;
      r_bdEx   <= bus.BD_ID;
    end
  end

  assign bus.code_EX   = r_codeEx;
  assign bus.PC_EX     = r_pcEx;
  assign bus.rsData_EX = r_rsEx;
  assign bus.rtData_EX = r_rtEx;
  assign bus.Exc_EX    = r_excEx;
  assign bus.BD_EX     = r_bdEx;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
// Self-checking bench for id_stage. The stimulus process drives one set of
// inputs per cycle and pushes the expected outputs (from a behavioural
// model) into a queue; a monitor pops and compares on each falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_id_stage;

  logic clk = 1'b0;
  logic reset;
  logic stall;
  logic clr;

  id_stage_if bus ();

  id_stage dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        clr;
    logic [31:0] code;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        fre;
    logic [31:0] fr;
    logic        fte;
    logic [31:0] ft;
  } stim_t;

  typedef struct {
    logic        cmp;
    logic [15:0] imm16;
    logic [25:0] jmpAddr;
    logic [31:0] jmpReg;
    logic [31:0] codeEx;
    logic [31:0] pcEx;
    logic [31:0] rsEx;
    logic [31:0] rtEx;
    logic [4:0]  excEx;
    logic        bdEx;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] mRegs [32];
  logic [31:0] mCodeEx, mPcEx, mRsEx, mRtEx;
  logic [4:0]  mExcEx;
  logic        mBdEx;

  int checks = 0;
  int fails  = 0;

  // Shared comparison helper: counts every comparison and reports misses.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.stall = 0; s.clr = 0;
    s.code = 0; s.pc = 0; s.exc = 0; s.bd = 0;
    s.we = 0; s.waddr = 0; s.wdata = 0;
    s.fre = 0; s.fr = 0; s.fte = 0; s.ft = 0;
    return s;
  endfunction

  // Model register read: r0 is zero; with write-through a same-cycle write
  // to the addressed register is returned instead of the stored value.
  function automatic logic [31:0] modelRead(input logic [4:0] addr, input stim_t s);
    if (addr == 0) return 32'd0;
`ifdef GRF_BYPASS_EN
    if (s.we && s.waddr != 0 && s.waddr == addr) return s.wdata;
`endif
    return mRegs[addr];
  endfunction

  // Branch outcome from the architectural definitions using signed arithmetic.
  function automatic logic modelCmp(input logic [31:0] code, input logic [31:0] a, input logic [31:0] b);
    int sa;
    sa = $signed(a);
    case (code[31:26])
      6'd4: return a == b;
      6'd5: return a != b;
      6'd6: return sa <= 0;
      6'd7: return sa > 0;
      6'd1: begin
        if (code[20:16] == 5'd0) return sa < 0;
        if (code[20:16] == 5'd1) return sa >= 0;
        return 1'b0;
      end
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle of inputs, queue the expected outputs for this cycle,
  // then advance the model across the coming clock edge.
  task automatic applyStimulus(input stim_t s, input bit check);
    exp_t        e;
    logic [31:0] a, b;
    @(posedge clk);
    #1;
    reset = s.rst; stall = s.stall; clr = s.clr;
    bus.code_ID = s.code; bus.PC_ID = s.pc; bus.Exc_ID = s.exc; bus.BD_ID = s.bd;
    bus.WB_we = s.we; bus.WB_addr = s.waddr; bus.WB_data = s.wdata;
    bus.fwdRsEn = s.fre; bus.fwdRs = s.fr; bus.fwdRtEn = s.fte; bus.fwdRt = s.ft;

    a = s.fre ? s.fr : modelRead(s.code[25:21], s);
    b = s.fte ? s.ft : modelRead(s.code[20:16], s);
    e.cmp = modelCmp(s.code, a, b);
    e.imm16 = s.code[15:0];
    e.jmpAddr = s.code[25:0];
    e.jmpReg = a;
    e.codeEx = mCodeEx; e.pcEx = mPcEx; e.rsEx = mRsEx; e.rtEx = mRtEx;
    e.excEx = mExcEx; e.bdEx = mBdEx;
    if (check) expQ.push_back(e);

    if (s.rst) begin
      for (int i = 0; i < 32; i++) mRegs[i] = 0;
      mCodeEx = 0; mPcEx = 0; mRsEx = 0; mRtEx = 0; mExcEx = 0; mBdEx = 0;
    end else begin
      if (s.we && s.waddr != 0) mRegs[s.waddr] = s.wdata;
      if (s.clr) begin
        mCodeEx = 0; mPcEx = 0; mRsEx = 0; mRtEx = 0; mExcEx = 0; mBdEx = 0;
      end else if (!s.stall) begin
        mCodeEx = s.code; mPcEx = s.pc; mRsEx = a; mRtEx = b; mExcEx = s.exc; mBdEx = s.bd;
      end
    end
  endtask

  function automatic logic [31:0] pickValue();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares every queued expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("cmp", {31'd0, bus.cmp}, {31'd0, e.cmp});
        checkOutput("imm16", {16'd0, bus.imm16}, {16'd0, e.imm16});
        checkOutput("jmpAddr", {6'd0, bus.jmpAddr}, {6'd0, e.jmpAddr});
        checkOutput("jmpReg", bus.jmpReg, e.jmpReg);
        checkOutput("code_EX", bus.code_EX, e.codeEx);
        checkOutput("PC_EX", bus.PC_EX, e.pcEx);
        checkOutput("rsData_EX", bus.rsData_EX, e.rsEx);
        checkOutput("rtData_EX", bus.rtData_EX, e.rtEx);
        checkOutput("Exc_EX", {27'd0, bus.Exc_EX}, {27'd0, e.excEx});
        checkOutput("BD_EX", {31'd0, bus.BD_EX}, {31'd0, e.bdEx});
      end
    end
  end

  initial begin
    stim_t       s;
    logic [31:0] heldCode;
    logic [31:0] bypassExp;
    logic [5:0]  ops [6];
    logic [4:0]  rsA;

    ops[0] = 6'd0; ops[1] = 6'd1; ops[2] = 6'd4;
    ops[3] = 6'd5; ops[4] = 6'd6; ops[5] = 6'd7;
    reset = 1'b1; stall = 1'b0; clr = 1'b0;
    for (int i = 0; i < 32; i++) mRegs[i] = 0;
    mCodeEx = 0; mPcEx = 0; mRsEx = 0; mRtEx = 0; mExcEx = 0; mBdEx = 0;

    // Initial reset; from here on the model is in step with the DUT.
    s = idle(); s.rst = 1;
    applyStimulus(s, 0);
    s = idle();
    applyStimulus(s, 1);
    @(negedge clk);
    checkOutput("reset_code_EX", bus.code_EX, 32'd0);

    // Register write then read back through rs.
    s = idle(); s.we = 1; s.waddr = 5; s.wdata = 32'h1234_5678;
    applyStimulus(s, 1);
    s = idle(); s.code = mk(6'd0, 5'd5, 5'd0, 16'h0); s.pc = 32'h40;
    applyStimulus(s, 1);
    @(negedge clk);
    checkOutput("read_reg5_jmpReg", bus.jmpReg, 32'h1234_5678);
    s = idle(); s.we = 1; s.waddr = 0; s.wdata = 32'hFFFF_FFFF;
    applyStimulus(s, 1);
    @(negedge clk);
    checkOutput("read_reg5_rsData_EX", bus.rsData_EX, 32'h1234_5678);
    s = idle(); s.code = mk(6'd4, 5'd0, 5'd0, 16'h0);
    applyStimulus(s, 1);
    @(negedge clk);
    checkOutput("reg0_jmpReg", bus.jmpReg, 32'd0);
    checkOutput("reg0_beq_cmp", {31'd0, bus.cmp}, 32'd1);

    // Branch comparisons.
    s = idle(); s.we = 1; s.waddr = 1; s.wdata = 32'hA5A5_A5A5;
    applyStimulus(s, 1);
    s = idle(); s.we = 1; s.waddr = 2; s.wdata = 32'hA5A5_A5A5;
    applyStimulus(s, 1);
    s = idle(); s.code = mk(6'd4, 5'd1, 5'd2, 16'h0010);
    applyStimulus(s, 1);
    @(negedge clk);
    checkOutput("beq_equal_cmp", {31'd0, bus.cmp}, 32'd1);
    s = idle(); s.code = mk(6'd7, 5'd9, 5'd0, 16'h0); s.fre = 1; s.fr = 32'h8000_0000;
    applyStimulus(s, 1);
    @(negedge clk);
    checkOutput("bgtz_neg_cmp", {31'd0, bus.cmp}, 32'd0);
    s = idle(); s.code = mk(6'd1, 5'd0, 5'd1, 16'h0);
    applyStimulus(s, 1);
    @(negedge clk);
    checkOutput("bgez_zero_cmp", {31'd0, bus.cmp}, 32'd1);

    // Forwarding beats the register file.
    s = idle(); s.we = 1; s.waddr = 3; s.wdata = 32'd1;
    applyStimulus(s, 1);
    s = idle(); s.code = mk(6'd4, 5'd3, 5'd3, 16'h0); s.fre = 1; s.fr = 32'd7;
    applyStimulus(s, 1);
    @(negedge clk);
    checkOutput("fwd_jmpReg", bus.jmpReg, 32'd7);
    checkOutput("fwd_beq_cmp", {31'd0, bus.cmp}, 32'd0);

    // Stall holds EX for three cycles, then clr with stall flushes.
    heldCode = mk(6'd5, 5'd1, 5'd3, 16'h1234);
    s = idle(); s.code = heldCode; s.pc = 32'h100; s.exc = 5'h15; s.bd = 1;
    applyStimulus(s, 1);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.stall = 1; s.code = mk(6'd6, 5'(i), 5'd0, 16'(i)); s.pc = 32'h200 + i;
      applyStimulus(s, 1);
    end
    s = idle(); s.stall = 1;
    applyStimulus(s, 1);
    @(negedge clk);
    checkOutput("stall_hold_code_EX", bus.code_EX, heldCode);
    checkOutput("stall_hold_PC_EX", bus.PC_EX, 32'h100);
    s = idle(); s.stall = 1; s.clr = 1; s.code = heldCode; s.pc = 32'h300;
    applyStimulus(s, 1);
    s = idle();
    applyStimulus(s, 1);
    @(negedge clk);
    checkOutput("clr_code_EX", bus.code_EX, 32'd0);
    checkOutput("clr_PC_EX", bus.PC_EX, 32'd0);
    checkOutput("clr_BD_EX", {31'd0, bus.BD_EX}, 32'd0);

    // Same-cycle write and read of r8.
    s = idle(); s.we = 1; s.waddr = 8; s.wdata = 32'h11;
    applyStimulus(s, 1);
    s = idle(); s.we = 1; s.waddr = 8; s.wdata = 32'h55; s.code = mk(6'd0, 5'd8, 5'd8, 16'h0);
    applyStimulus(s, 1);
`ifdef GRF_BYPASS_EN
    bypassExp = 32'h55;
`else
    bypassExp = 32'h11;
`endif
    @(negedge clk);
    checkOutput("bypass_jmpReg", bus.jmpReg, bypassExp);
    s = idle(); s.code = mk(6'd0, 5'd8, 5'd0, 16'h0);
    applyStimulus(s, 1);
    @(negedge clk);
    checkOutput("after_write_jmpReg", bus.jmpReg, 32'h55);

    // Fill every register, then reset mid-stall with a coincident write.
    for (int i = 1; i < 32; i++) begin
      s = idle(); s.we = 1; s.waddr = 5'(i); s.wdata = 32'h0101_0101 * i;
      s.code = mk(6'd4, 5'(i), 5'(32 - i), 16'(i)); s.pc = 32'(i * 4);
      applyStimulus(s, 1);
    end
    s = idle(); s.stall = 1; s.code = mk(6'd5, 5'd7, 5'd9, 16'h7);
    applyStimulus(s, 1);
    s = idle(); s.rst = 1; s.stall = 1; s.we = 1; s.waddr = 7; s.wdata = 32'hDEAD_BEEF;
    s.code = mk(6'd5, 5'd7, 5'd9, 16'h7);
    applyStimulus(s, 1);
    for (int i = 0; i < 16; i++) begin
      s = idle(); s.code = mk(6'd0, 5'(2 * i), 5'(2 * i + 1), 16'h0);
      applyStimulus(s, 1);
      @(negedge clk);
      checkOutput("post_reset_jmpReg", bus.jmpReg, 32'd0);
      if (i == 0) begin
        checkOutput("post_reset_code_EX", bus.code_EX, 32'd0);
        checkOutput("post_reset_PC_EX", bus.PC_EX, 32'd0);
      end
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 59) == 0);
      s.stall = ($urandom_range(0, 4) == 0);
      s.clr   = ($urandom_range(0, 9) == 0);
      rsA = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 6) == 0) begin
        s.code = $urandom;
      end else begin
        s.code = mk(ops[$urandom_range(0, 5)], rsA, 5'($urandom_range(0, 31)), 16'($urandom));
        if (s.code[31:26] == 6'd1) s.code[20:16] = 5'($urandom_range(0, 3));
      end
      s.pc  = $urandom;
      s.exc = 5'($urandom);
      s.bd  = 1'($urandom);
      s.we  = ($urandom_range(0, 1) == 1);
      s.waddr = ($urandom_range(0, 2) == 0) ? s.code[25:21] : 5'($urandom_range(0, 31));
      s.wdata = pickValue();
      s.fre = ($urandom_range(0, 3) == 0);
      s.fr  = pickValue();
      s.fte = ($urandom_range(0, 3) == 0);
      s.ft  = pickValue();
      applyStimulus(s, 1);
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have inputs stall (1, hold EX registers) and clr (1, flush EX registers to zero).
REQ-004 The block SHALL have inputs code_ID[31:0], PC_ID[31:0], Exc_ID[6:2] and BD_ID (1), driven by the fetch-stage pipeline registers.
REQ-005 The block SHALL have inputs WB_we (1), WB_addr[4:0] and WB_data[31:0], forming the register-file write port from writeback.
REQ-006 The block SHALL have inputs fwdRsEn (1), fwdRs[31:0], fwdRtEn (1) and fwdRt[31:0], carrying forwarded operands from later stages.
REQ-007 The block SHALL have outputs cmp (1), imm16[15:0], jmpAddr[25:0] and jmpReg[31:0] to the fetch stage's next-PC logic; these are combinational.
REQ-008 The block SHALL have registered outputs code_EX[31:0], PC_EX[31:0], rsData_EX[31:0], rtData_EX[31:0], Exc_EX[6:2] and BD_EX (1).
REQ-009 Parameter: none. Macro: GRF_BYPASS_EN (REQ-022).

Function
REQ-010 Register file: 32 x 32 bit; a read of register 0 SHALL always return 0.
REQ-011 Write: at posedge, when WB_we=1 and WB_addr!=0, reg[WB_addr] <= WB_data; a write to register 0 SHALL be ignored.
REQ-012 Field extraction: rs=code_ID[25:21], rt=code_ID[20:16], imm16=code_ID[15:0], jmpAddr=code_ID[25:0].
REQ-013 Operand select for rs, in priority order: fwdRsEn ? fwdRs : (bypass, REQ-022) : reg[rs]. rt SHALL use the same priority with fwdRtEn/fwdRt.
REQ-014 jmpReg SHALL equal the selected rs operand.
REQ-015 cmp, with A = selected rs and B = selected rt, by opcode code_ID[31:26]:
- 000100 beq: A==B
- 000101 bne: A!=B
- 000110 blez: signed A<=0
- 000111 bgtz: signed A>0
- 000001 with rt=00000 bltz: A[31]
- 000001 with rt=00001 bgez: !A[31]
- all other opcodes: 0
REQ-016 EX registers: if reset|clr, all registered outputs SHALL load 0; else if !stall, they SHALL load code_ID, PC_ID, the selected rs and rt operands, Exc_ID and BD_ID; else they SHALL hold.
REQ-017 clr SHALL take priority over stall.
REQ-018 Latency: one cycle from ID inputs to EX outputs; cmp, imm16, jmpAddr and jmpReg have zero latency.
REQ-019 A register write and an EX-register load in the same edge SHALL both occur.
REQ-020 A stall SHALL NOT block register-file writes.
REQ-021 code_ID=0 (bubble) SHALL produce cmp=0 and propagate as a zero-valued bubble.

Configuration
REQ-022 With GRF_BYPASS_EN defined: when WB_we=1, WB_addr!=0 and WB_addr equals the read address, the read SHALL return WB_data in the same cycle (write-through). Without the macro, the read SHALL return the pre-write array value, and the write becomes visible the next cycle.

Reset
REQ-023 On reset, all 32 registers and all EX outputs SHALL be 0 after the edge.
REQ-024 A reset asserted mid-stall SHALL override the stall.
REQ-025 A WB write coincident with reset SHALL be discarded.

Verification
REQ-026 Write/read: write reg5=0x12345678, then code_ID with rs=5 -> rsData_EX=0x12345678 one cycle later; a write of 0xFFFFFFFF to reg0 -> reads of reg0 return 0.
REQ-027 Branch compare: beq with rs=rt=0xA5A5A5A5 -> cmp=1; bgtz with rs=0x80000000 -> cmp=0; bgez with rs=0 -> cmp=1.
REQ-028 Forward priority: reg3=1, fwdRsEn=1, fwdRs=7 and a beq with rs=rt=3 -> jmpReg=7, cmp=0.
REQ-029 Stall/clr: stall=1 for 3 cycles -> EX outputs hold; stall=1 and clr=1 together -> all EX outputs =0.
REQ-030 Bypass: WB_we=1, WB_addr=8, WB_data=0x55 while code_ID reads rs=8 -> with GRF_BYPASS_EN, jmpReg=0x55 that cycle; without it, jmpReg = the old value.
REQ-031 Reset: load regs 1-31, pulse reset for 1 cycle -> all reads return 0 and all EX outputs are 0.
